// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and default width for the multiply/divide unit.
package mdu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the register-file stage and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = mdu_pkg::DEF_WIDTH
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_iter_core.sv
// One shift-add (multiply) or restoring-subtract (divide) step per enabled cycle on unsigned magnitudes.
// nxt_hi/nxt_lo show the post-step value combinationally so the final step can be committed on the same edge.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             load,
  input  logic             load_div,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] load_opnd,
  input  logic             step,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             is_div;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] trial;

  always_comb begin
    sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Extra headroom bit so a zero divisor never looks like a borrow.
    trial = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, opnd};
    if (is_div) begin
      if (trial[WIDTH+1]) begin
        nxt_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end else begin
        nxt_hi = trial[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:1]};
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= load_lo;
      opnd   <= load_opnd;
      is_div <= load_div;
      cnt    <= '0;
    end else if (step) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: 33-cycle mul/div, 1-cycle MTHI/MTLO; starts are ignored while busy.
// MDU_SINGLE_CYCLE_MULT_EN selects a combinational multiplier (MULT/MULTU finish in 1 cycle).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic            clk,
  input logic            reset_b,
  mult_div_unit_if.slave bus
);

  state_e           state;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;
  logic             neg_res, neg_rem, div_zero, is_div;

  logic             sgn, a_neg, b_neg, req_div, accept, core_load, core_last;
  logic [WIDTH-1:0] mag_a, mag_b, core_hi, core_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign sgn     = is_signed_op(bus.op);
  assign a_neg   = sgn & bus.src_a[WIDTH-1];
  assign b_neg   = sgn & bus.src_b[WIDTH-1];
  assign mag_a   = a_neg ? -bus.src_a : bus.src_a;
  assign mag_b   = b_neg ? -bus.src_b : bus.src_b;
  assign req_div = is_div_op(bus.op);
  assign accept  = (state == ST_IDLE) && bus.start && !bus.cancel;

`ifdef MDU_SINGLE_CYCLE_MULT_EN
  logic [2*WIDTH-1:0] fast_mag, fast_prod;
  assign fast_mag  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
  assign core_load = accept && req_div;
`else
  assign core_load = accept && (req_div || bus.op == OP_MULT || bus.op == OP_MULTU);
`endif

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset_b   (reset_b),
    .load      (core_load),
    .load_div  (req_div),
    .load_lo   (req_div ? mag_a : mag_b),
    .load_opnd (req_div ? mag_b : mag_a),
    .step      (state == ST_CALC),
    .nxt_hi    (core_hi),
    .nxt_lo    (core_lo),
    .last      (core_last)
  );

  // Divide by zero reports all-ones quotient; the remainder path already rebuilds src_a.
  assign prod_fix = neg_res ? -{core_hi, core_lo} : {core_hi, core_lo};
  assign quo_fix  = div_zero ? {WIDTH{1'b1}} : (neg_res ? -core_lo : core_lo);
  assign rem_fix  = neg_rem ? -core_hi : core_hi;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (bus.src_b == '0);
            is_div   <= req_div;
            case (bus.op)
              OP_MTHI: begin
                hi_q <= bus.src_a; state <= ST_FIN; busy_q <= 1'b1; done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q <= bus.src_a; state <= ST_FIN; busy_q <= 1'b1; done_q <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                state <= ST_CALC; busy_q <= 1'b1;
              end
              OP_MULT, OP_MULTU: begin
`ifdef MDU_SINGLE_CYCLE_MULT_EN
                hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
                lo_q   <= fast_prod[WIDTH-1:0];
                state  <= ST_FIN;
                busy_q <= 1'b1;
                done_q <= 1'b1;
`else
                state  <= ST_CALC;
                busy_q <= 1'b1;
`endif
              end
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          if (bus.cancel) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (core_last) begin
            hi_q   <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_q   <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
            state  <= ST_FIN;
            done_q <= 1'b1;
          end
        end
        ST_FIN: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, cancel, reset and busy-ignore behaviour.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_SINGLE_CYCLE_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t mul_vec [4] = '{
    '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
    '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F},
    '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001}
  };

  vec_t div_vec [5] = '{
    '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{OP_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF},
    '{OP_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF},
    '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{OP_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E}
  };

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle number in which done was seen (40 on timeout).
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 1; busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.hi !== '0)     begin n_bad++; $display("FAIL reset hi: got %h want 0", bus.hi); end
    n_cmp++; if (bus.lo !== '0)     begin n_bad++; $display("FAIL reset lo: got %h want 0", bus.lo); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", bus.done); end
    #4 reset_b = 1'b1;
    tick();
  endtask

  task automatic test_mthi_mtlo();
    issue(OP_MTHI, 32'hCAFEF00D, 32'h0);
    n_cmp++; if (bus.hi !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mthi hi: got %h want cafef00d", bus.hi); end
    n_cmp++; if ({bus.done, bus.busy} !== 2'b11) begin n_bad++; $display("FAIL mthi done/busy: got %b want 11", {bus.done, bus.busy}); end
    tick();
    n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL mthi idle: got %b want 00", {bus.done, bus.busy}); end
    issue(OP_MTLO, 32'h12345678, 32'h0);
    n_cmp++; if (bus.lo !== 32'h12345678) begin n_bad++; $display("FAIL mtlo lo: got %h want 12345678", bus.lo); end
    n_cmp++; if (bus.hi !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mtlo hi: got %h want cafef00d", bus.hi); end
    n_cmp++; if ({bus.done, bus.busy} !== 2'b11) begin n_bad++; $display("FAIL mtlo done/busy: got %b want 11", {bus.done, bus.busy}); end
    tick();
  endtask

  task automatic test_unknown_op();
    issue(3'd7, 32'hDEADBEEF, 32'h1);
    n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL unknown op busy: got %b want 00", {bus.done, bus.busy}); end
    tick();
    n_cmp++; if ({bus.hi, bus.lo} !== {32'hCAFEF00D, 32'h12345678}) begin n_bad++; $display("FAIL unknown op hilo: got %h want cafef00d12345678", {bus.hi, bus.lo}); end
  endtask

  task automatic test_cancel_idle();
    bit seen = 1'b0;
    bus.cancel = 1'b1;
    issue(OP_MULTU, 32'h5, 32'h5);
    bus.cancel = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL cancel idle busy: got %b want 0", bus.busy); end
    for (int c = 0; c < 36; c++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL cancel idle done: got %b want 0", seen); end
    n_cmp++; if ({bus.hi, bus.lo} !== {32'hCAFEF00D, 32'h12345678}) begin n_bad++; $display("FAIL cancel idle hilo: got %h want cafef00d12345678", {bus.hi, bus.lo}); end
  endtask

  task automatic test_cancel_calc();
    bit seen = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) tick();
    bus.start = 1'b1; bus.op = OP_MULT; bus.src_a = 32'd3; bus.src_b = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL cancel calc state: got %b want 00", {bus.done, bus.busy}); end
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL cancel calc activity: got %b want 0", seen); end
    n_cmp++; if ({bus.hi, bus.lo} !== {32'hCAFEF00D, 32'h12345678}) begin n_bad++; $display("FAIL cancel calc hilo: got %h want cafef00d12345678", {bus.hi, bus.lo}); end
  endtask

  task automatic test_reset_mid();
    int lat; bit bok;
    issue(OP_DIVU, 32'hFFFFFFFF, 32'd3);
    repeat (14) tick();
    #2 reset_b = 1'b0;
    #1;
    n_cmp++; if ({bus.hi, bus.lo} !== 64'h0) begin n_bad++; $display("FAIL async reset hilo: got %h want 0", {bus.hi, bus.lo}); end
    n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL async reset done/busy: got %b want 00", {bus.done, bus.busy}); end
    tick();
    #3 reset_b = 1'b1;
    tick();
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(lat, bok);
    n_cmp++; if (lat !== MUL_LAT) begin n_bad++; $display("FAIL post-reset mul latency: got %0d want %0d", lat, MUL_LAT); end
    n_cmp++; if ({bus.hi, bus.lo} !== 64'd12) begin n_bad++; $display("FAIL post-reset mul hilo: got %h want 12", {bus.hi, bus.lo}); end
    tick();
  endtask

  task automatic test_multiply();
    int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      issue(mul_vec[i].op, mul_vec[i].a, mul_vec[i].b);
      wait_done(lat, bok);
      n_cmp++; if (lat !== MUL_LAT) begin n_bad++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, MUL_LAT); end
      n_cmp++; if ((bok && bus.busy === 1'b1) !== 1'b1) begin n_bad++; $display("FAIL mul[%0d] busy span: got %b want 1", i, bok && bus.busy === 1'b1); end
      n_cmp++; if (bus.hi !== mul_vec[i].hi) begin n_bad++; $display("FAIL mul[%0d] hi: got %h want %h", i, bus.hi, mul_vec[i].hi); end
      n_cmp++; if (bus.lo !== mul_vec[i].lo) begin n_bad++; $display("FAIL mul[%0d] lo: got %h want %h", i, bus.lo, mul_vec[i].lo); end
      tick();
      n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL mul[%0d] release: got %b want 00", i, {bus.done, bus.busy}); end
    end
  endtask

  task automatic test_divide();
    int lat; bit bok;
    for (int i = 0; i < 5; i++) begin
      issue(div_vec[i].op, div_vec[i].a, div_vec[i].b);
      wait_done(lat, bok);
      n_cmp++; if (lat !== DIV_LAT) begin n_bad++; $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, DIV_LAT); end
      n_cmp++; if ((bok && bus.busy === 1'b1) !== 1'b1) begin n_bad++; $display("FAIL div[%0d] busy span: got %b want 1", i, bok && bus.busy === 1'b1); end
      n_cmp++; if (bus.hi !== div_vec[i].hi) begin n_bad++; $display("FAIL div[%0d] hi: got %h want %h", i, bus.hi, div_vec[i].hi); end
      n_cmp++; if (bus.lo !== div_vec[i].lo) begin n_bad++; $display("FAIL div[%0d] lo: got %h want %h", i, bus.lo, div_vec[i].lo); end
      tick();
      n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL div[%0d] release: got %b want 00", i, {bus.done, bus.busy}); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat; bit bok;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) tick();
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd9; bus.src_b = 32'd9;
    tick();
    bus.start = 1'b0;
    wait_done(lat, bok);
    n_cmp++; if (lat !== DIV_LAT - 5) begin n_bad++; $display("FAIL busy ignore latency: got %0d want %0d", lat, DIV_LAT - 5); end
    n_cmp++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL busy ignore hilo: got %h want %h", {bus.hi, bus.lo}, {32'd2, 32'd14}); end
    tick();
    tick();
    n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL busy ignore no restart: got %b want 00", {bus.done, bus.busy}); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;
    #8;
    test_reset();
    test_mthi_mtlo();
    test_unknown_op();
    test_cancel_idle();
    test_cancel_calc();
    test_reset_mid();
    test_multiply();
    test_divide();
    test_busy_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
